// File: rtl/pine_bus_pkg.sv
// pine_bus_pkg: shared FSM states, port owner encoding and bus widths for bus_unit
package pine_bus_pkg;
  localparam int ADR_W = 20;
  localparam int DAT_W = 16;
  localparam int WS_DEF = 2;
  localparam int TMO_DEF = 255;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;
  typedef enum logic {OWN_I, OWN_D} own_e;
endpackage

// File: rtl/bus_arb.sv
// bus_arb: picks the fetch or data port for the next memory access
// ireq/dreq: pending requests; last: owner of the previous grant; grant: chosen port
module bus_arb
  import pine_bus_pkg::*;
(
  input  logic ireq,
  input  logic dreq,
  input  own_e last,
  output own_e grant
);
  // data normally wins; fetch wins a contention straight after a data grant
  assign grant = (dreq && !(ireq && last == OWN_D)) ? OWN_D : OWN_I;
endmodule

// File: rtl/bus_unit.sv
// bus_unit: single-transaction memory bus shared by the fetch and data ports
// clk/rst: clock and synchronous active-high reset
// ireq/iadr -> iack/idata: fetch port; dreq/dwe/dadr/dwdata/dbe -> dack/drdata: data port
// berr: pulses with the ack of a timed-out access
// mem_*: external memory, mem_rdy completes an access once the wait states have elapsed
module bus_unit
  import pine_bus_pkg::*;
#(
  parameter int WS  = WS_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ireq,
  input  logic [ADR_W-1:0] iadr,
  output logic             iack,
  output logic [DAT_W-1:0] idata,
  input  logic             dreq,
  input  logic             dwe,
  input  logic [ADR_W-1:0] dadr,
  input  logic [DAT_W-1:0] dwdata,
  input  logic [1:0]       dbe,
  output logic             dack,
  output logic [DAT_W-1:0] drdata,
  output logic             berr,
  output logic [ADR_W-1:0] mem_adr,
  output logic [DAT_W-1:0] mem_dout,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [1:0]       mem_be,
  input  logic [DAT_W-1:0] mem_din,
  input  logic             mem_rdy
);
  state_e state_q;
  own_e own_q, last_q, grant;
  logic [3:0] wait_q;
  logic [15:0] tmo_q;
  logic [ADR_W-1:0] mem_adr_q;
  logic [DAT_W-1:0] mem_dout_q, idata_q, drdata_q, rdata;
  logic [1:0] mem_be_q;
  logic mem_cs_q, mem_we_q, iack_q, dack_q, berr_q, fin, is_d, wr;
  bus_arb u_arb (
    .ireq  (ireq),
    .dreq  (dreq),
    .last  (last_q),
    .grant (grant)
  );
  assign is_d = grant == OWN_D;
  assign wr = is_d && dwe;
  // the access ends once wait states are spent and memory is ready or the timeout budget is used up
  assign fin = state_q == ST_ACCESS && wait_q == 4'd0 && (mem_rdy || tmo_q == 16'(TMO));
  assign rdata = mem_rdy ? mem_din : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      own_q <= OWN_I;
      last_q <= OWN_I;
      wait_q <= '0;
      tmo_q <= '0;
      mem_adr_q <= '0;
      mem_dout_q <= '0;
      mem_be_q <= '0;
      mem_cs_q <= 1'b0;
      mem_we_q <= 1'b0;
      idata_q <= '0;
      drdata_q <= '0;
      iack_q <= 1'b0;
      dack_q <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      iack_q <= 1'b0;
      dack_q <= 1'b0;
      berr_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (ireq || dreq) begin
          state_q <= ST_ACCESS;
          own_q <= grant;
          last_q <= grant;
          mem_cs_q <= 1'b1;
          mem_we_q <= wr;
          mem_adr_q <= is_d ? dadr : iadr;
          mem_dout_q <= dwdata;
          mem_be_q <= wr ? dbe : 2'b11;
          wait_q <= 4'(WS);
          tmo_q <= '0;
        end
        ST_ACCESS: if (wait_q != 4'd0) begin
          wait_q <= wait_q - 4'd1;
        end else if (fin) begin
          state_q <= ST_DONE;
          mem_cs_q <= 1'b0;
          mem_we_q <= 1'b0;
          iack_q <= own_q == OWN_I;
          dack_q <= own_q == OWN_D;
          berr_q <= !mem_rdy;
          if (own_q == OWN_I) idata_q <= rdata;
          else if (!mem_we_q) drdata_q <= rdata;
        end else begin
          tmo_q <= tmo_q + 16'd1;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign iack = iack_q;
  assign dack = dack_q;
  assign berr = berr_q;
  assign idata = idata_q;
  assign drdata = drdata_q;
  assign mem_adr = mem_adr_q;
  assign mem_dout = mem_dout_q;
  assign mem_be = mem_be_q;
  assign mem_cs = mem_cs_q;
  assign mem_we = mem_we_q;
endmodule

// File: tb/tb_bus_unit.sv
// tb_bus_unit: two bus_unit configurations checked against a transaction-level model
module tb_bus_unit;
  localparam int WS0 = 0, TMO0 = 4, WS1 = 2, TMO1 = 3;
  typedef struct packed {
    logic cs, we;
    logic [19:0] adr;
    logic [15:0] dout;
    logic [1:0] be;
    logic iack, dack, berr;
    logic [15:0] idata, drdata;
  } outs_t;
  logic clk = 1'b0, rst = 1'b1;
  logic ireq[2], iack[2], dreq[2], dwe[2], dack[2], berr[2], mem_cs[2], mem_we[2], mem_rdy[2];
  logic [19:0] iadr[2], dadr[2], mem_adr[2];
  logic [15:0] idata[2], dwdata[2], drdata[2], mem_dout[2], mem_din[2], dsave[2];
  logic [1:0] dbe[2], mem_be[2];
  outs_t exp_o[2];
  bit busy[2], fin[2], own_d[2], last_d[2], wr[2], ip[2], dp[2], bd[2];
  int wl[2], nr[2], burst[2], ic[2], dc[2], ifirst[2], dfirst[2], nack[2], wec[2];
  logic [7:0] ord[2];
  int kc, rdy_mode, n_chk, n_err, acks_total;
  bit noise, drop;
  always #5 clk = ~clk;
  bus_unit #(.WS(WS0), .TMO(TMO0)) u0 (
    .clk(clk), .rst(rst), .ireq(ireq[0]), .iadr(iadr[0]), .iack(iack[0]), .idata(idata[0]),
    .dreq(dreq[0]), .dwe(dwe[0]), .dadr(dadr[0]), .dwdata(dwdata[0]), .dbe(dbe[0]),
    .dack(dack[0]), .drdata(drdata[0]), .berr(berr[0]), .mem_adr(mem_adr[0]),
    .mem_dout(mem_dout[0]), .mem_cs(mem_cs[0]), .mem_we(mem_we[0]), .mem_be(mem_be[0]),
    .mem_din(mem_din[0]), .mem_rdy(mem_rdy[0])
  );
  bus_unit #(.WS(WS1), .TMO(TMO1)) u1 (
    .clk(clk), .rst(rst), .ireq(ireq[1]), .iadr(iadr[1]), .iack(iack[1]), .idata(idata[1]),
    .dreq(dreq[1]), .dwe(dwe[1]), .dadr(dadr[1]), .dwdata(dwdata[1]), .dbe(dbe[1]),
    .dack(dack[1]), .drdata(drdata[1]), .berr(berr[1]), .mem_adr(mem_adr[1]),
    .mem_dout(mem_dout[1]), .mem_cs(mem_cs[1]), .mem_we(mem_we[1]), .mem_be(mem_be[1]),
    .mem_din(mem_din[1]), .mem_rdy(mem_rdy[1])
  );
  function automatic int ws_of(int l);
    return l == 0 ? WS0 : WS1;
  endfunction
  function automatic int tmo_of(int l);
    return l == 0 ? TMO0 : TMO1;
  endfunction
  function automatic logic [15:0] mem_word(logic [19:0] a);
    return a[15:0] ^ {a[19:16], 12'h000} ^ 16'hA54A;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // transaction view: one access in flight, WS wait cycles, then ready or TMO extra not-ready cycles
  task automatic adv(int l);
    exp_o[l].iack = 1'b0;
    exp_o[l].dack = 1'b0;
    exp_o[l].berr = 1'b0;
    if (rst) begin
      exp_o[l] = '0;
      busy[l] = 0;
      fin[l] = 0;
      last_d[l] = 0;
    end else if (fin[l]) begin
      fin[l] = 0;
    end else if (!busy[l]) begin
      if (ireq[l] || dreq[l]) begin
        own_d[l] = (ireq[l] && dreq[l]) ? !last_d[l] : dreq[l];
        last_d[l] = own_d[l];
        wr[l] = own_d[l] && dwe[l];
        busy[l] = 1;
        wl[l] = ws_of(l);
        nr[l] = 0;
        exp_o[l].cs = 1'b1;
        exp_o[l].we = wr[l];
        exp_o[l].adr = own_d[l] ? dadr[l] : iadr[l];
        exp_o[l].dout = dwdata[l];
        exp_o[l].be = wr[l] ? dbe[l] : 2'b11;
      end
    end else if (wl[l] > 0) begin
      wl[l]--;
    end else if (mem_rdy[l] || nr[l] == tmo_of(l)) begin
      busy[l] = 0;
      fin[l] = 1;
      exp_o[l].cs = 1'b0;
      exp_o[l].we = 1'b0;
      exp_o[l].berr = !mem_rdy[l];
      if (own_d[l]) begin
        exp_o[l].dack = 1'b1;
        if (!wr[l]) exp_o[l].drdata = mem_rdy[l] ? mem_din[l] : 16'h0;
      end else begin
        exp_o[l].iack = 1'b1;
        exp_o[l].idata = mem_rdy[l] ? mem_din[l] : 16'h0;
      end
    end else begin
      nr[l]++;
    end
  endtask
  task automatic clr_stats();
    kc = 0;
    for (int l = 0; l < 2; l++) begin
      ic[l] = 0; dc[l] = 0; ifirst[l] = -1; dfirst[l] = -1;
      nack[l] = 0; wec[l] = 0; ord[l] = 8'h01; bd[l] = 0;
    end
  endtask
  task automatic tick();
    for (int l = 0; l < 2; l++) begin
      if (rdy_mode == 1) begin
        if (burst[l] > 0) begin
          burst[l]--;
          mem_rdy[l] = 1'b0;
        end else begin
          if ($urandom_range(0, 39) == 0) burst[l] = $urandom_range(2, 7);
          mem_rdy[l] = $urandom_range(0, 2) != 0;
        end
      end else begin
        mem_rdy[l] = rdy_mode == 0;
      end
      mem_din[l] = mem_word(mem_adr[l]) ^ (noise ? 16'($urandom) : 16'h0);
      adv(l);
    end
    @(negedge clk);
    kc++;
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("L%0d mem_cs", l), 32'(mem_cs[l]), 32'(exp_o[l].cs));
      chk($sformatf("L%0d mem_we", l), 32'(mem_we[l]), 32'(exp_o[l].we));
      chk($sformatf("L%0d mem_adr", l), 32'(mem_adr[l]), 32'(exp_o[l].adr));
      chk($sformatf("L%0d mem_dout", l), 32'(mem_dout[l]), 32'(exp_o[l].dout));
      chk($sformatf("L%0d mem_be", l), 32'(mem_be[l]), 32'(exp_o[l].be));
      chk($sformatf("L%0d iack", l), 32'(iack[l]), 32'(exp_o[l].iack));
      chk($sformatf("L%0d dack", l), 32'(dack[l]), 32'(exp_o[l].dack));
      chk($sformatf("L%0d berr", l), 32'(berr[l]), 32'(exp_o[l].berr));
      chk($sformatf("L%0d idata", l), 32'(idata[l]), 32'(exp_o[l].idata));
      chk($sformatf("L%0d drdata", l), 32'(drdata[l]), 32'(exp_o[l].drdata));
      if (mem_we[l] === 1'b1 && mem_be[l] === 2'b01) wec[l]++;
      if (iack[l] === 1'b1) begin
        ic[l]++; acks_total++;
        if (ifirst[l] < 0) ifirst[l] = kc;
        if (nack[l] < 4) ord[l] = {ord[l][6:0], 1'b0};
        nack[l]++;
        if (drop) ireq[l] = 1'b0;
      end
      if (dack[l] === 1'b1) begin
        dc[l]++; acks_total++;
        if (dfirst[l] < 0) dfirst[l] = kc;
        if (nack[l] < 4) ord[l] = {ord[l][6:0], 1'b1};
        nack[l]++;
        bd[l] = berr[l];
        if (drop) dreq[l] = 1'b0;
      end
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    for (int l = 0; l < 2; l++) begin
      ireq[l] = 1'b0; dreq[l] = 1'b0;
    end
    tick();
    rst = 1'b0;
  endtask
  initial begin
    n_chk = 0; n_err = 0; acks_total = 0;
    rdy_mode = 0; noise = 0; drop = 1;
    for (int l = 0; l < 2; l++) begin
      ireq[l] = 0; dreq[l] = 0; dwe[l] = 0; iadr[l] = '0; dadr[l] = '0;
      dwdata[l] = '0; dbe[l] = '0; burst[l] = 0; ip[l] = 0; dp[l] = 0;
    end
    clr_stats();
    do_reset();
    tick();
    // fetch with no wait states on lane 0, two on lane 1
    for (int l = 0; l < 2; l++) begin ireq[l] = 1'b1; iadr[l] = 20'h00010; end
    clr_stats();
    tick();
    for (int l = 0; l < 2; l++) chk($sformatf("L%0d cs_cycle1", l), 32'(mem_cs[l]), 32'd1);
    repeat (8) tick();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("L%0d fetch_latency", l), 32'(ifirst[l]), 32'(2 + ws_of(l)));
      chk($sformatf("L%0d fetch_data", l), 32'(idata[l]), 32'h0000A55A);
      chk($sformatf("L%0d fetch_acks", l), 32'(ic[l]), 32'd1);
    end
    // data read, then a byte write that must leave drdata alone
    for (int l = 0; l < 2; l++) begin dreq[l] = 1'b1; dwe[l] = 1'b0; dadr[l] = 20'h00200; end
    clr_stats();
    repeat (10) tick();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("L%0d read_data", l), 32'(drdata[l]), 32'(mem_word(20'h00200)));
      dsave[l] = mem_word(20'h00200);
      dreq[l] = 1'b1; dwe[l] = 1'b1; dadr[l] = 20'h00100; dwdata[l] = 16'h1234; dbe[l] = 2'b01;
    end
    clr_stats();
    repeat (10) tick();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("L%0d write_we_cycles", l), 32'(wec[l]), 32'(1 + ws_of(l)));
      chk($sformatf("L%0d write_latency", l), 32'(dfirst[l]), 32'(2 + ws_of(l)));
      chk($sformatf("L%0d write_keeps_drdata", l), 32'(drdata[l]), 32'(dsave[l]));
      dwe[l] = 1'b0;
    end
    // contention straight out of reset alternates starting with data
    do_reset();
    drop = 0;
    for (int l = 0; l < 2; l++) begin ireq[l] = 1'b1; dreq[l] = 1'b1; iadr[l] = 20'h00020; dadr[l] = 20'h00030; end
    clr_stats();
    repeat (22) tick();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("L%0d grant_order", l), 32'(ord[l]), 32'h1A);
      ireq[l] = 1'b0; dreq[l] = 1'b0;
    end
    drop = 1;
    repeat (8) tick();
    // fetch flushed one cycle after grant still completes once, then data is served
    do_reset();
    for (int l = 0; l < 2; l++) begin ireq[l] = 1'b1; iadr[l] = 20'h00333; end
    clr_stats();
    tick();
    for (int l = 0; l < 2; l++) begin ireq[l] = 1'b0; dreq[l] = 1'b1; dwe[l] = 1'b0; dadr[l] = 20'h00444; end
    repeat (15) tick();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("L%0d flush_iacks", l), 32'(ic[l]), 32'd1);
      chk($sformatf("L%0d flush_dacks", l), 32'(dc[l]), 32'd1);
      chk($sformatf("L%0d flush_order", l), 32'(ord[l]), 32'h05);
    end
    // memory never ready: bus error after the timeout budget, read data forced to zero
    rdy_mode = 2;
    for (int l = 0; l < 2; l++) begin dreq[l] = 1'b1; dwe[l] = 1'b0; dadr[l] = 20'h00500; end
    clr_stats();
    repeat (16) tick();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("L%0d timeout_latency", l), 32'(dfirst[l]), 32'(2 + ws_of(l) + tmo_of(l)));
      chk($sformatf("L%0d timeout_berr", l), 32'(bd[l]), 32'd1);
      chk($sformatf("L%0d timeout_drdata", l), 32'(drdata[l]), 32'd0);
    end
    // reset in the middle of an access aborts it silently
    for (int l = 0; l < 2; l++) begin dreq[l] = 1'b1; dadr[l] = 20'h00600; end
    clr_stats();
    repeat (3) tick();
    do_reset();
    for (int l = 0; l < 2; l++) chk($sformatf("L%0d reset_cs", l), 32'(mem_cs[l]), 32'd0);
    repeat (8) tick();
    for (int l = 0; l < 2; l++) chk($sformatf("L%0d reset_no_ack", l), 32'(ic[l] + dc[l]), 32'd0);
    rdy_mode = 0;
    for (int l = 0; l < 2; l++) begin ireq[l] = 1'b1; iadr[l] = 20'h00010; end
    clr_stats();
    repeat (8) tick();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("L%0d post_reset_latency", l), 32'(ifirst[l]), 32'(2 + ws_of(l)));
      chk($sformatf("L%0d post_reset_data", l), 32'(idata[l]), 32'h0000A55A);
    end
    // randomized traffic with flushes, stalls, timeouts and the odd reset
    rdy_mode = 1; noise = 1; drop = 0; acks_total = 0;
    repeat (3000) begin
      rst = $urandom_range(0, 499) == 0;
      for (int l = 0; l < 2; l++) begin
        if (rst) begin
          ip[l] = 0; dp[l] = 0;
        end else begin
          if (iack[l]) ip[l] = 0;
          else if (!ip[l]) ip[l] = $urandom_range(0, 3) == 0;
          else if ($urandom_range(0, 29) == 0) ip[l] = 0;
          if (dack[l]) dp[l] = 0;
          else if (!dp[l]) dp[l] = $urandom_range(0, 3) == 0;
          else if ($urandom_range(0, 29) == 0) dp[l] = 0;
        end
        ireq[l] = ip[l]; dreq[l] = dp[l];
        iadr[l] = 20'($urandom); dadr[l] = 20'($urandom); dwdata[l] = 16'($urandom);
        dbe[l] = 2'($urandom); dwe[l] = 1'($urandom);
      end
      tick();
    end
    chk("random_traffic_acks", 32'(acks_total > 100), 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
